// File: rtl/sw_filter_ctrl_if.sv
// Window-memory bus between the filter controller (master) and the dual-image memory (slave).
// Latency: none, wires only; the memory registers requests on its own side.
// Backpressure: none; the master holds rd/wr for fixed cycle counts instead of a handshake.
interface sw_filter_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rd;
  logic [ADDR_W-1:0] addr_row_r;
  logic [ADDR_W-1:0] addr_col_r;
  logic [DATA_W-1:0] sw_pixel_1;
  logic [DATA_W-1:0] sw_pixel_2;
  logic [DATA_W-1:0] sw_pixel_3;
  logic [DATA_W-1:0] sw_pixel_4;
  logic [DATA_W-1:0] sw_pixel_5;
  logic [DATA_W-1:0] sw_pixel_6;
  logic [DATA_W-1:0] sw_pixel_7;
  logic [DATA_W-1:0] sw_pixel_8;
  logic [DATA_W-1:0] sw_pixel_9;
  logic              wr;
  logic [ADDR_W-1:0] addr_row_w;
  logic [ADDR_W-1:0] addr_col_w;
  logic [DATA_W-1:0] cl_pixel;

  modport master (
    output rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel,
    input  sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5,
           sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9
  );

  modport slave (
    input  rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel,
    output sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5,
           sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9
  );
endinterface

// File: rtl/sw_filter_ctrl.sv
// 3x3 Gaussian filter controller: scans every window of n_image, writes the result into f_image.
// Latency: RD_LAT + WR_LAT + 3 cycles per window; done one cycle after the last window's NEXT.
// Backpressure: none; memory must honour the fixed rd/wr hold times, start is ignored while busy.
module sw_filter_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  sw_filter_ctrl_if.master  mem
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, COMPUTE, WRITE, NEXT, DONE} state_t;

  localparam int SUM_W   = DATA_W + 4;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LAT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] row, col;
  logic [DATA_W-1:0] win [9];
  logic [SUM_W-1:0]  gauss_sum;
  logic              rd_last, wr_last, last_col, last_row;

  // Last window column/row; counters stop here so they never wrap.
  assign last_col = (col == ADDR_W'(IMG_W - 3));
  assign last_row = (row == ADDR_W'(IMG_H - 3));
  assign rd_last  = (lat_cnt == LAT_W'(RD_LAT - 1));
  assign wr_last  = (lat_cnt == LAT_W'(WR_LAT - 1));

  // Kernel 1 2 1 / 2 4 2 / 1 2 1 as shifts; 16*max pixel fits in SUM_W bits.
  assign gauss_sum = SUM_W'(win[0])        + (SUM_W'(win[1]) << 1) + SUM_W'(win[2])
                   + (SUM_W'(win[3]) << 1) + (SUM_W'(win[4]) << 2) + (SUM_W'(win[5]) << 1)
                   + SUM_W'(win[6])        + (SUM_W'(win[7]) << 1) + SUM_W'(win[8]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one window per READ..NEXT loop, raster order.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (rd_last) state_nxt = CAPTURE;
      CAPTURE: state_nxt = COMPUTE;
      COMPUTE: state_nxt = WRITE;
      WRITE:   if (wr_last) state_nxt = NEXT;
      NEXT:    state_nxt = (last_col && last_row) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs: addresses are only driven while their request is high.
  always_comb begin
    mem.rd         = (state == READ);
    mem.wr         = (state == WRITE);
    mem.addr_row_r = '0;
    mem.addr_col_r = '0;
    mem.addr_row_w = '0;
    mem.addr_col_w = '0;
    if (state == READ) begin
      mem.addr_row_r = row;
      mem.addr_col_r = col;
    end
    if (state == WRITE) begin
      mem.addr_row_w = row + ADDR_W'(1);
      mem.addr_col_w = col + ADDR_W'(1);
    end
  end

  // Counters, hold-time timer, result register and frame status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt      <= '0;
      row          <= '0;
      col          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.cl_pixel <= '0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          row     <= '0;
          col     <= '0;
          lat_cnt <= '0;
          busy    <= 1'b1;
        end
        READ:    lat_cnt <= rd_last ? '0 : lat_cnt + LAT_W'(1);
        COMPUTE: mem.cl_pixel <= gauss_sum[SUM_W-1:4];
        WRITE:   lat_cnt <= wr_last ? '0 : lat_cnt + LAT_W'(1);
        NEXT: begin
          if (!last_col) begin
            col <= col + ADDR_W'(1);
          end else if (!last_row) begin
            col <= '0;
            row <= row + ADDR_W'(1);
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Window capture: memory has driven the pixels by the cycle after the read burst.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      win[0] <= mem.sw_pixel_1;
      win[1] <= mem.sw_pixel_2;
      win[2] <= mem.sw_pixel_3;
      win[3] <= mem.sw_pixel_4;
      win[4] <= mem.sw_pixel_5;
      win[5] <= mem.sw_pixel_6;
      win[6] <= mem.sw_pixel_7;
      win[7] <= mem.sw_pixel_8;
      win[8] <= mem.sw_pixel_9;
    end
  end

endmodule

// File: tb/tb_sw_filter_ctrl.sv
// Bench for sw_filter_ctrl: a 3x3 instance and a 5x4 instance, each with a latched-address memory model.
// Expected writes come from a direct Gaussian-over-image reference, in raster order.
// Monitors record rd/wr bursts on the falling edge; the main thread compares them.
module tb_sw_filter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_v [2];
  logic busy_v  [2];
  logic done_v  [2];

  sw_filter_ctrl_if #(.ADDR_W(8), .DATA_W(8)) ma ();
  sw_filter_ctrl_if #(.ADDR_W(8), .DATA_W(8)) mb ();

  sw_filter_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(2), .WR_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]), .mem(ma.master)
  );

  sw_filter_ctrl #(.IMG_W(5), .IMG_H(4), .ADDR_W(8), .DATA_W(8), .RD_LAT(2), .WR_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]), .mem(mb.master)
  );

  // Per-instance views of the bus.
  logic rd_s [2];
  logic wr_s [2];
  int   ar_s [2], ac_s [2], wrr_s [2], wrc_s [2], pix_s [2];
  assign rd_s[0]  = ma.rd;                 assign rd_s[1]  = mb.rd;
  assign wr_s[0]  = ma.wr;                 assign wr_s[1]  = mb.wr;
  assign ar_s[0]  = int'(ma.addr_row_r);   assign ar_s[1]  = int'(mb.addr_row_r);
  assign ac_s[0]  = int'(ma.addr_col_r);   assign ac_s[1]  = int'(mb.addr_col_r);
  assign wrr_s[0] = int'(ma.addr_row_w);   assign wrr_s[1] = int'(mb.addr_row_w);
  assign wrc_s[0] = int'(ma.addr_col_w);   assign wrc_s[1] = int'(mb.addr_col_w);
  assign pix_s[0] = int'(ma.cl_pixel);     assign pix_s[1] = int'(mb.cl_pixel);

  // Memory model: registers the read address, then drives the window from that address.
  logic [7:0] img [2][8][8];
  int la_r [2] = '{0, 0};
  int la_c [2] = '{0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_s[i]) begin
        la_r[i] <= ar_s[i];
        la_c[i] <= ac_s[i];
      end
    end
  end

  assign ma.sw_pixel_1 = img[0][la_r[0]  ][la_c[0]  ];
  assign ma.sw_pixel_2 = img[0][la_r[0]  ][la_c[0]+1];
  assign ma.sw_pixel_3 = img[0][la_r[0]  ][la_c[0]+2];
  assign ma.sw_pixel_4 = img[0][la_r[0]+1][la_c[0]  ];
  assign ma.sw_pixel_5 = img[0][la_r[0]+1][la_c[0]+1];
  assign ma.sw_pixel_6 = img[0][la_r[0]+1][la_c[0]+2];
  assign ma.sw_pixel_7 = img[0][la_r[0]+2][la_c[0]  ];
  assign ma.sw_pixel_8 = img[0][la_r[0]+2][la_c[0]+1];
  assign ma.sw_pixel_9 = img[0][la_r[0]+2][la_c[0]+2];
  assign mb.sw_pixel_1 = img[1][la_r[1]  ][la_c[1]  ];
  assign mb.sw_pixel_2 = img[1][la_r[1]  ][la_c[1]+1];
  assign mb.sw_pixel_3 = img[1][la_r[1]  ][la_c[1]+2];
  assign mb.sw_pixel_4 = img[1][la_r[1]+1][la_c[1]  ];
  assign mb.sw_pixel_5 = img[1][la_r[1]+1][la_c[1]+1];
  assign mb.sw_pixel_6 = img[1][la_r[1]+1][la_c[1]+2];
  assign mb.sw_pixel_7 = img[1][la_r[1]+2][la_c[1]  ];
  assign mb.sw_pixel_8 = img[1][la_r[1]+2][la_c[1]+1];
  assign mb.sw_pixel_9 = img[1][la_r[1]+2][la_c[1]+2];

  // Edge counter: value k is visible from the k-th rising edge onward.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Burst monitors: one queue entry per rd/wr burst, plus hold-time and overlap tallies.
  int run_rd [2] = '{0, 0};
  int run_wr [2] = '{0, 0};
  int cur_r [2] = '{0, 0};
  int cur_w [2] = '{0, 0};
  int bad_len [2] = '{0, 0};
  int unstable [2] = '{0, 0};
  int overlap [2] = '{0, 0};
  int busy_cyc [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int rq [2][$];
  int wq [2][$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        run_rd[i] <= 0;
        run_wr[i] <= 0;
      end else begin
        if (rd_s[i]) begin
          if (run_rd[i] == 0) begin
            cur_r[i] <= ar_s[i] * 256 + ac_s[i];
            rq[i].push_back(ar_s[i] * 256 + ac_s[i]);
          end else if (ar_s[i] * 256 + ac_s[i] != cur_r[i]) begin
            unstable[i] <= unstable[i] + 1;
          end
          run_rd[i] <= run_rd[i] + 1;
        end else if (run_rd[i] != 0) begin
          if (run_rd[i] != 2) bad_len[i] <= bad_len[i] + 1;
          run_rd[i] <= 0;
        end
        if (wr_s[i]) begin
          if (run_wr[i] == 0) begin
            cur_w[i] <= (wrr_s[i] << 16) | (wrc_s[i] << 8) | pix_s[i];
            wq[i].push_back((wrr_s[i] << 16) | (wrc_s[i] << 8) | pix_s[i]);
          end else if (((wrr_s[i] << 16) | (wrc_s[i] << 8) | pix_s[i]) != cur_w[i]) begin
            unstable[i] <= unstable[i] + 1;
          end
          run_wr[i] <= run_wr[i] + 1;
        end else if (run_wr[i] != 0) begin
          if (run_wr[i] != 2) bad_len[i] <= bad_len[i] + 1;
          run_wr[i] <= 0;
        end
        if (rd_s[i] && wr_s[i]) overlap[i] <= overlap[i] + 1;
        if (busy_v[i]) busy_cyc[i] <= busy_cyc[i] + 1;
        if (done_v[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          done_cyc[i] <= cyc;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: weighted 3x3 sum of the source image divided by 16, rounded down.
  function automatic int gauss_ref(input int i, input int r, input int c);
    int s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += int'(img[i][r+dr][c+dc]) * ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
    return s / 16;
  endfunction

  task automatic fill(input int i, input int kind);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (kind)
          0:       img[i][r][c] = 8'd16;
          1:       img[i][r][c] = (r == 1 && c == 1) ? 8'd255 : 8'd0;
          2:       img[i][r][c] = 8'd255;
          3:       img[i][r][c] = (r == 0 && c == 0) ? 8'd1 : 8'd0;
          4:       img[i][r][c] = 8'(r * 3 + c + 1);
          default: img[i][r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start_v[i] = 1'b1;
    @(posedge clk); #1 start_v[i] = 1'b0;
  endtask

  // One full frame on instance i, compared burst-by-burst against the reference.
  task automatic frame(input int i, input int w, input int h, input bit poke);
    int nwin = (w - 2) * (h - 2);
    int nr = rq[i].size();
    int nw = wq[i].size();
    int dc = done_cnt[i];
    int bc = busy_cyc[i];
    int bl = bad_len[i];
    int us = unstable[i];
    int ov = overlap[i];
    int s;
    int k;
    pulse_start(i);
    s = cyc;
    check("busy_set", int'(busy_v[i]), 1);
    if (poke) begin
      repeat (10) @(posedge clk);
      pulse_start(i);
    end
    k = 0;
    while (done_cnt[i] == dc && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", int'(done_cnt[i] != dc), 1);
    check("done_latency", done_cyc[i] - s, nwin * 7 + 1);
    check("busy_clr", int'(busy_v[i]), 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt[i] - dc, 1);
    check("busy_cycles", busy_cyc[i] - bc, nwin * 7 + 1);
    check("n_reads", rq[i].size() - nr, nwin);
    check("n_writes", wq[i].size() - nw, nwin);
    for (int r = 0; r < h - 2; r++) begin
      for (int c = 0; c < w - 2; c++) begin
        int idx = r * (w - 2) + c;
        if (nr + idx < rq[i].size()) check("rd_addr", rq[i][nr + idx], r * 256 + c);
        if (nw + idx < wq[i].size())
          check("wr_addr_pix", wq[i][nw + idx], ((r + 1) << 16) | ((c + 1) << 8) | gauss_ref(i, r, c));
      end
    end
    check("burst_len", bad_len[i] - bl, 0);
    check("hold_stable", unstable[i] - us, 0);
    check("rd_wr_overlap", overlap[i] - ov, 0);
  endtask

  int exp_a [5] = '{16, 63, 255, 0, 5};

  initial begin
    int nw;
    int k;
    rst = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    fill(0, 5);
    fill(1, 5);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_a", int'(busy_v[0]), 0);
    check("rst_done_a", int'(done_v[0]), 0);
    check("rst_rd_a", int'(ma.rd), 0);
    check("rst_wr_a", int'(ma.wr), 0);
    check("rst_pix_a", pix_s[0], 0);
    check("rst_addr_a", ar_s[0] + ac_s[0] + wrr_s[0] + wrc_s[0], 0);
    check("rst_busy_b", int'(busy_v[1]), 0);
    check("rst_done_b", int'(done_v[1]), 0);
    check("rst_rd_b", int'(mb.rd), 0);
    check("rst_wr_b", int'(mb.wr), 0);
    check("rst_pix_b", pix_s[1], 0);
    check("rst_addr_b", ar_s[1] + ac_s[1] + wrr_s[1] + wrc_s[1], 0);
    rst = 1'b0;

    // 3x3 image: single window, directed values then random ones.
    for (int kind = 0; kind < 5; kind++) begin
      fill(0, kind);
      frame(0, 3, 3, 1'b0);
      if (wq[0].size() > 0) check("dir_val", wq[0][$] & 255, exp_a[kind]);
    end
    for (int n = 0; n < 3; n++) begin
      fill(0, 5);
      frame(0, 3, 3, 1'b0);
    end

    // 5x4 image: start ignored while busy, then back-to-back frame after done.
    fill(1, 5);
    frame(1, 5, 4, 1'b1);
    fill(1, 5);
    frame(1, 5, 4, 1'b0);

    // Reset while the second window is being written, then a clean restart.
    nw = wq[1].size();
    pulse_start(1);
    k = 0;
    while (wq[1].size() < nw + 2 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_reached_wr2", wq[1].size() - nw, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_wr", int'(mb.wr), 0);
    check("midrst_rd", int'(mb.rd), 0);
    check("midrst_busy", int'(busy_v[1]), 0);
    check("midrst_done", int'(done_v[1]), 0);
    check("midrst_pix", pix_s[1], 0);
    check("midrst_addr", wrr_s[1] + wrc_s[1], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nw = rq[1].size();
    fill(1, 5);
    frame(1, 5, 4, 1'b0);
    if (rq[1].size() > nw) check("restart_addr", rq[1][nw], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_filter_ctrl.md
Name: sw_filter_ctrl

Overview:
- Initiator and compute side for the dual-image window memory (`n_image` read, `f_image` write).
- Scans every valid 3x3 window of the source image in raster order and issues read requests for each window.
- Captures the nine window pixels and applies a 3x3 Gaussian kernel (1 2 1 / 2 4 2 / 1 2 1, divided by 16).
- Writes each result back to the filtered image at the window centre; one `start` pulse processes a whole frame.

Parameters:
- IMG_W, 256, image width in pixels (min 3, max 2^ADDR_W).
- IMG_H, 256, image height in pixels (min 3, max 2^ADDR_W).
- ADDR_W, 8, row/column address width.
- DATA_W, 8, pixel width.
- RD_LAT, 2, cycles `rd` is held high per window with a stable address (memory registers the address, then drives the pixels).
- WR_LAT, 2, cycles `wr` is held high per result with stable address and data (memory registers address and data, then writes).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse after the last write of the frame.
- rd  out  1  window read request.
- addr_row_r  out  ADDR_W  top-left row of the current window.
- addr_col_r  out  ADDR_W  top-left column of the current window.
- sw_pixel_1..sw_pixel_9  in  DATA_W each  window pixels, row-major; 1 = top-left, 5 = centre, 9 = bottom-right.
- wr  out  1  filtered pixel write request.
- addr_row_w  out  ADDR_W  write row (window row + 1).
- addr_col_w  out  ADDR_W  write column (window column + 1).
- cl_pixel  out  DATA_W  filtered pixel value.

Behaviour:
- Reset: state IDLE; all outputs 0 (`busy`, `done`, `rd`, `wr`, `addr_*`, `cl_pixel`); row/column counters 0.
- FSM states: IDLE, READ, CAPTURE, COMPUTE, WRITE, NEXT, DONE.
- IDLE
  - `start` = 1 -> READ, with counters r = 0, c = 0; `busy` goes to 1 on the same edge.
  - `start` is ignored in every other state.
- READ
  - `rd` = 1 for exactly RD_LAT consecutive cycles.
  - `addr_row_r` = r and `addr_col_r` = c, held stable throughout.
  - Then -> CAPTURE with `rd` = 0.
- CAPTURE: register all nine `sw_pixel` inputs; -> COMPUTE.
- COMPUTE
  - sum = p1 + 2*p2 + p3 + 2*p4 + 4*p5 + 2*p6 + p7 + 2*p8 + p9.
  - Computed in DATA_W+4 bits; max 255*16 = 4080, so there is no overflow.
  - `cl_pixel` <= sum >> 4 (truncation, no rounding; the result always fits DATA_W).
  - -> WRITE.
- WRITE
  - `wr` = 1 for exactly WR_LAT consecutive cycles.
  - `addr_row_w` = r+1, `addr_col_w` = c+1 and `cl_pixel` held stable throughout.
  - Then -> NEXT with `wr` = 0.
- NEXT (no bus activity)
  - If c < IMG_W-3: c <= c+1 -> READ.
  - Else if r < IMG_H-3: c <= 0, r <= r+1 -> READ.
  - Else -> DONE.
- DONE: `done` = 1 for one cycle, `busy` <= 0, -> IDLE.
- Timing and mutual exclusion:
  - `rd` and `wr` are never high in the same cycle.
  - Per-window cost = RD_LAT + WR_LAT + 3 cycles (7 with defaults).
  - Frame windows = (IMG_W-2)*(IMG_H-2).
- Boundaries:
  - Border pixels (row/col 0 and IMG-1) are never written.
  - Counter increments never wrap, because the last window column is IMG_W-3.
  - IMG_W = IMG_H = 3 gives exactly one window.
- Reset mid-frame: same-cycle return to IDLE with all outputs 0; any in-progress `rd`/`wr` is dropped; a new `start` restarts from (0,0).

Test Plan:
- IMG_W=IMG_H=3, all nine pixels = 16, `start` -> `rd` high exactly 2 cycles at (0,0); `wr` high 2 cycles at (1,1) with `cl_pixel` = 16; `done` pulses 8 cycles after the `start` edge.
- IMG 3x3, only the centre = 255 and others 0 -> `cl_pixel` = 63; then all = 255 -> `cl_pixel` = 255 (no overflow).
- IMG 3x3, p1=1, p2..p9=0 -> `cl_pixel` = 0 (truncation); pixels 1..9 -> sum 80 -> `cl_pixel` = 5.
- IMG_W=5, IMG_H=4 -> 6 writes in order (1,1),(1,2),(1,3),(2,1),(2,2),(2,3); `busy` high throughout; `rd` and `wr` never overlap; one `done` pulse.
- `start` pulsed while busy -> ignored, frame write count unchanged; `start` after `done` -> second full frame.
- `rst` asserted during WRITE of window 2 -> next cycle `wr`/`rd`/`busy` = 0; new `start` -> first read address (0,0).
